// File: rtl/symbol_packer.sv
// Byte aligner/packer for the 2-bit mux stream: hunts for a comma symbol,
// then packs four MSB-first symbols per byte and strobes each completed byte.
module symbol_packer #(
    parameter logic [7:0] COMMA    = 8'hBC,
    parameter int         IDLE_MAX = 8
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       valid_in,
    input  logic [1:0] data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       locked
);

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state, state_n;
    logic [7:0] sr, sr_n;
    logic [2:0] fill, fill_n;
    logic [1:0] sym_cnt, sym_cnt_n;
    logic [3:0] idle_cnt, idle_cnt_n;
    logic [7:0] data_n;
    logic       valid_n;
    logic [7:0] nxt;

    assign nxt    = {sr[5:0], data_in};
    assign locked = (state == LOCKED);

    // State register plus all datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= SEARCH;
            sr        <= 8'h00;
            fill      <= 3'd0;
            sym_cnt   <= 2'd0;
            idle_cnt  <= 4'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            fill      <= fill_n;
            sym_cnt   <= sym_cnt_n;
            idle_cnt  <= idle_cnt_n;
            data_out  <= data_n;
            valid_out <= valid_n;
        end
    end

    always_comb begin
        state_n    = state;
        sr_n       = sr;
        fill_n     = fill;
        sym_cnt_n  = sym_cnt;
        idle_cnt_n = idle_cnt;
        data_n     = data_out;
        valid_n    = 1'b0;

        if (valid_in) begin
            sr_n = nxt;
        end

        case (state)
            SEARCH: begin
                if (valid_in) begin
                    if ((fill >= 3'd3) && (nxt == COMMA)) begin
                        state_n    = LOCKED;
                        sym_cnt_n  = 2'd0;
                        idle_cnt_n = 4'd0;
                    end else if (fill < 3'd4) begin
                        fill_n = fill + 3'd1;
                    end
                end
            end
            LOCKED: begin
                // A comma landing on a byte boundary is swallowed silently.
                if (valid_in) begin
                    idle_cnt_n = 4'd0;
                    sym_cnt_n  = sym_cnt + 2'd1;
                    if ((sym_cnt == 2'd3) && (nxt != COMMA)) begin
                        data_n  = nxt;
                        valid_n = 1'b1;
                    end
                end else if (idle_cnt == 4'(IDLE_MAX - 1)) begin
                    state_n    = SEARCH;
                    fill_n     = 3'd0;
                    sym_cnt_n  = 2'd0;
                    idle_cnt_n = 4'd0;
                end else begin
                    idle_cnt_n = idle_cnt + 4'd1;
                end
            end
            default: begin
                state_n = SEARCH;
                fill_n  = 3'd0;
            end
        endcase
    end

endmodule
